// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes fetch bundles and hands them to execute
// through a registered output slot backed by one skid entry.
module alu_issue_decode #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_funct5,
  output logic            out_bit30,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_alu1_pc,
  output logic            out_alu2_imm,
  output logic            out_reg_we,
  output logic            out_is_branch,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_illegal
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_ARI_I  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ARI_R  = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [4:0]      funct5;
    logic            bit30;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            alu1_pc;
    logic            alu2_imm;
    logic            reg_we;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            is_load;
    logic            is_store;
    logic            illegal;
  } bundle_t;

  localparam bundle_t RESET_BUNDLE = '{pc: RESET_PC_TAG, default: '0};

  logic [31:0] ins;
  logic [4:0]  f5;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        known_op;
  logic        writes_rd;
  logic        bad_encoding;
  bundle_t     dec;

  assign ins = in_instr;
  assign f5  = ins[6:2];
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  // Immediate formatting and opcode classification
  always_comb begin
    dec          = '0;
    known_op     = 1'b1;
    writes_rd    = 1'b0;
    bad_encoding = 1'b0;
    dec.pc       = in_pc;
    dec.funct3   = f3;
    dec.funct5   = f5;
    dec.bit30    = ins[30];
    dec.rs1      = ins[19:15];
    dec.rs2      = ins[24:20];
    dec.rd       = ins[11:7];
    dec.alu1_pc  = (f5 == OP_AUIPC) || (f5 == OP_JAL) || (f5 == OP_BRANCH);
    dec.alu2_imm = (f5 != OP_ARI_R);
    case (f5)
      OP_LOAD, OP_ARI_I, OP_JALR, OP_SYSTEM: begin
        dec.imm   = {{20{ins[31]}}, ins[31:20]};
        writes_rd = 1'b1;
      end
      OP_STORE:  dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH: dec.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC: begin
        dec.imm   = {ins[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OP_JAL: begin
        dec.imm   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OP_ARI_R:  writes_rd = 1'b1;
      default:   known_op  = 1'b0;
    endcase

    if (f5 == OP_ARI_R) begin
      if (f7 == 7'b0100000) bad_encoding = (f3 != 3'b000) && (f3 != 3'b101);
      else                  bad_encoding = (f7 != 7'b0000000);
    end else if (f5 == OP_ARI_I) begin
      if (f3 == 3'b001)      bad_encoding = (f7 != 7'b0000000);
      else if (f3 == 3'b101) bad_encoding = (f7 != 7'b0000000) && (f7 != 7'b0100000);
    end

    dec.illegal   = (ins[1:0] != 2'b11) || !known_op || bad_encoding;
    dec.reg_we    = writes_rd && (ins[11:7] != 5'd0) && !dec.illegal;
    dec.is_branch = (f5 == OP_BRANCH) && !dec.illegal;
    dec.is_jal    = (f5 == OP_JAL)    && !dec.illegal;
    dec.is_jalr   = (f5 == OP_JALR)   && !dec.illegal;
    dec.is_load   = (f5 == OP_LOAD)   && !dec.illegal;
    dec.is_store  = (f5 == OP_STORE)  && !dec.illegal;
  end

  bundle_t out_q;
  bundle_t skid_q;
  logic    out_valid_q;
  logic    skid_valid_q;
  logic    accept;
  logic    out_free;

  assign in_ready = ~skid_valid_q & ~flush;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

  // The skid entry only fills while the output slot is stalled, so it always
  // holds the younger of the two bundles and drains first when the slot frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= RESET_BUNDLE;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= accept;
        if (accept) skid_q <= dec;
      end else begin
        out_valid_q <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_funct3    = out_q.funct3;
  assign out_funct5    = out_q.funct5;
  assign out_bit30     = out_q.bit30;
  assign out_imm       = out_q.imm;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_alu1_pc   = out_q.alu1_pc;
  assign out_alu2_imm  = out_q.alu2_imm;
  assign out_reg_we    = out_q.reg_we;
  assign out_is_branch = out_q.is_branch;
  assign out_is_jal    = out_q.is_jal;
  assign out_is_jalr   = out_q.is_jalr;
  assign out_is_load   = out_q.is_load;
  assign out_is_store  = out_q.is_store;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Randomized bench for alu_issue_decode: an in-order queue of accepted
// instructions plus a behavioural decoder predict every emitted bundle.
module tb_alu_issue_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [2:0]  out_funct3;
  logic [4:0]  out_funct5;
  logic        out_bit30;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_alu1_pc, out_alu2_imm, out_reg_we;
  logic        out_is_branch, out_is_jal, out_is_jalr, out_is_load, out_is_store;
  logic        out_illegal;

  alu_issue_decode #(.XLEN(32), .RESET_PC_TAG(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_funct3(out_funct3), .out_funct5(out_funct5), .out_bit30(out_bit30),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu1_pc(out_alu1_pc), .out_alu2_imm(out_alu2_imm), .out_reg_we(out_reg_we),
    .out_is_branch(out_is_branch), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] dut_ctrl;
  assign dut_ctrl = {out_funct3, out_funct5, out_bit30, out_rs1, out_rs2, out_rd,
                     out_alu1_pc, out_alu2_imm, out_reg_we, out_is_branch, out_is_jal,
                     out_is_jalr, out_is_load, out_is_store, out_illegal};

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic        last_acc;
  logic [63:0] inflight[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference decoder: immediates assembled arithmetically from field values
  function automatic void ref_decode(input logic [31:0] w, output logic [31:0] imm,
                                     output logic [31:0] ctrl);
    int          sx;
    int          f5, f3, f7, rd;
    bit          known, ill, we;
    sx = $signed(w);
    f5 = int'(w[6:2]); f3 = int'(w[14:12]); f7 = int'(w[31:25]); rd = int'(w[11:7]);
    known = f5 inside {0, 4, 5, 8, 12, 13, 24, 25, 27, 28};
    ill = (w[1:0] != 2'b11) || !known
       || (f5 == 12 && !(f7 == 0 || f7 == 32))
       || (f5 == 12 && f7 == 32 && !(f3 == 0 || f3 == 5))
       || (f5 == 4 && f3 == 1 && f7 != 0)
       || (f5 == 4 && f3 == 5 && !(f7 == 0 || f7 == 32));
    case (f5)
      0, 4, 25, 28: imm = sx >>> 20;
      8:            imm = (sx >>> 25) * 32 + rd;
      24:           imm = (sx >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                          + int'(w[11:8]) * 2;
      13, 5:        imm = w - (w % 4096);
      27:           imm = (sx >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                          + int'(w[30:21]) * 2;
      default:      imm = 0;
    endcase
    we = !ill && (rd != 0) && (f5 inside {0, 4, 5, 12, 13, 25, 27, 28});
    ctrl = {w[14:12], w[6:2], w[30], w[19:15], w[24:20], w[11:7],
            1'(f5 == 5 || f5 == 27 || f5 == 24), 1'(f5 != 12), 1'(we),
            1'(!ill && f5 == 24), 1'(!ill && f5 == 27), 1'(!ill && f5 == 25),
            1'(!ill && f5 == 0), 1'(!ill && f5 == 8), 1'(ill)};
  endfunction

  // Called #1 after a rising edge; checks before the next edge, then advances.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    logic [31:0] e_imm, e_ctrl;
    logic        e_ready, e_valid, cons;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
    #4;
    e_valid = (inflight.size() > 0);
    e_ready = (inflight.size() < 2) && !fl;
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    if (e_valid) begin
      ref_decode(inflight[0][31:0], e_imm, e_ctrl);
      checkOutput("out_pc", out_pc, inflight[0][63:32]);
      checkOutput("out_imm", out_imm, e_imm);
      checkOutput("out_ctrl", dut_ctrl, e_ctrl);
    end
    last_acc = v && e_ready;
    cons = e_valid && rdy;
    @(posedge clk);
    #1;
    if (fl) inflight.delete();
    else begin
      if (cons) begin
        void'(inflight.pop_front());
        pops++;
      end
      if (last_acc) inflight.push_back({pc, w});
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  ops [10] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                              5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) w[6:2] = ops[sel];
    if ($urandom_range(0, 15) != 0) w[1:0] = 2'b11;
    case ($urandom_range(0, 3))
      0, 3:    w[31:25] = 7'b0000000;
      1:       w[31:25] = 7'b0100000;
      default: ;
    endcase
    return w;
  endfunction

  logic [31:0] bp_list [4] = '{32'h002081B3, 32'h00500093, 32'hFE208CE3, 32'h123452B7};

  initial begin
    int idx;
    int pops0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_pc", out_pc, 32'h0000_0000);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    checkOutput("rst_ctrl", dut_ctrl, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1, 32'h002081B3, 32'h100, 1, 0);
    checkOutput("add_funct5", {27'd0, out_funct5}, 32'h0C);
    checkOutput("add_rd", {27'd0, out_rd}, 32'd3);
    checkOutput("add_rs2", {27'd0, out_rs2}, 32'd2);
    checkOutput("add_we", {31'd0, out_reg_we}, 32'd1);
    checkOutput("add_alu2", {31'd0, out_alu2_imm}, 32'd0);
    applyStimulus(1, 32'h402081B3, 32'h104, 1, 0);
    checkOutput("sub_bit30", {31'd0, out_bit30}, 32'd1);
    applyStimulus(1, 32'hFFF00093, 32'h108, 1, 0);
    checkOutput("addi_imm", out_imm, 32'hFFFFFFFF);
    checkOutput("addi_alu2", {31'd0, out_alu2_imm}, 32'd1);
    applyStimulus(1, 32'h123452B7, 32'h10C, 1, 0);
    checkOutput("lui_imm", out_imm, 32'h12345000);
    applyStimulus(1, 32'hFE208CE3, 32'h110, 1, 0);
    checkOutput("beq_imm", out_imm, 32'hFFFFFFF8);
    checkOutput("beq_branch", {31'd0, out_is_branch}, 32'd1);
    checkOutput("beq_we", {31'd0, out_reg_we}, 32'd0);
    applyStimulus(1, 32'h00000000, 32'h114, 1, 0);
    checkOutput("zero_illegal", {31'd0, out_illegal}, 32'd1);
    applyStimulus(1, 32'h202081B3, 32'h118, 1, 0);
    checkOutput("f7_illegal", {31'd0, out_illegal}, 32'd1);
    applyStimulus(1, 32'h00100013, 32'h11C, 1, 0);
    checkOutput("x0_we", {31'd0, out_reg_we}, 32'd0);
    checkOutput("x0_illegal", {31'd0, out_illegal}, 32'd0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Backpressure: fetch holds each instruction until it is taken
    idx = 0;
    pops0 = pops;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(idx < 4, bp_list[idx % 4], 32'h200 + 32'(idx * 4), c >= 4, 0);
      if (last_acc) idx++;
    end
    checkOutput("bp_accepted", 32'(idx), 32'd4);
    checkOutput("bp_emerged", 32'(pops - pops0), 32'd4);

    // Flush with two bundles buffered
    applyStimulus(1, 32'h00108093, 32'h300, 0, 0);
    applyStimulus(1, 32'h00210113, 32'h304, 0, 0);
    applyStimulus(1, 32'h00318193, 32'h308, 1, 1);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 32'h0, 32'h0, 1, 0);

    // Async reset mid-stream
    applyStimulus(1, 32'h00408213, 32'h400, 0, 0);
    applyStimulus(1, 32'h00510293, 32'h404, 0, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("arst_ready", {31'd0, in_ready}, 32'd1);
    inflight.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1, 32'h00618313, 32'h500, 1, 0);
    checkOutput("arst_first_pc", out_pc, 32'h500);

    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 3) != 0, gen_instr(), $urandom & 32'hFFFFFFFC,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_decode.md
Name: alu_issue_decode

Overview:
- Decode/issue stage that sits directly upstream of the combinational ALU.
- Takes raw RV32I instruction words plus PC from fetch over a valid/ready handshake.
- Registers them and presents the ALU control fields (funct3, funct5, bit30), operand-select controls, the immediate and register indices to execute over a second valid/ready handshake.
- A two-entry skid buffer decouples in_ready from out_ready.

Parameters:
- XLEN, 32, datapath width of pc/imm; only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, value driven on out_pc while out_valid=0 after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; synchronously released by the system.
- flush  in  1  kill all buffered instructions (branch/jump redirect).
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- out_pc  out  32  PC passthrough.
- out_funct3  out  3  instr[14:12].
- out_funct5  out  5  instr[6:2], opcode with low bits dropped.
- out_bit30  out  1  instr[30].
- out_imm  out  32  sign-extended immediate per format.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_alu1_pc  out  1  1 = ALU operand1 is PC (AUIPC, JAL, branch target).
- out_alu2_imm  out  1  1 = ALU operand2 is imm (all except R-type).
- out_reg_we  out  1  writes rd (0 forced when rd==0).
- out_is_branch, out_is_jal, out_is_jalr, out_is_load, out_is_store  out  1 each.
- out_illegal  out  1  instruction not decodable.

Behaviour:
- Reset (rst_n=0, immediate): both buffer entries invalid; out_valid=0, in_ready=1.
- Reset values: all out_* data = 0, except out_pc = RESET_PC_TAG.
- Latency: an instruction accepted at edge N appears on out_* after edge N (one cycle), if the output register is free.
- Outputs are registered; no combinational path from in_* to out_*.
- in_ready = ~skid_valid & ~flush; depends only on registered state and flush.
- Transfers: accept = in_valid & in_ready; consume = out_valid & out_ready.
- Output register empty or consumed:
  - loads from the skid entry if it is valid, otherwise from the input on accept.
  - if skid drained and accept in the same cycle, the input goes to skid.
- Output register held (out_valid & ~out_ready) and accept: the decoded input goes to skid.
- Order is strictly preserved; no bundle is ever dropped or duplicated.
- Decode is performed before buffering; the skid stores decoded fields.
- Immediate formats, all sign-extended from instr[31]:
  - I-type: LOAD 00000, ARI_I 00100, JALR 11001, SYSTEM 11100.
  - S-type: STORE 01000.
  - B-type: BRANCH 11000; imm[0]=0.
  - U-type: LUI 01101, AUIPC 00101; low 12 bits 0.
  - J-type: JAL 11011; imm[0]=0.
  - Other opcodes: imm=0.
- out_bit30 passes raw instr[30]; the ALU qualifies it.
- Illegal when any of:
  - instr[1:0]≠2'b11.
  - funct5 not in the list above.
  - R-type with instr[31:25] not 0000000/0100000.
  - R-type with 0100000 and funct3 ∉ {000,101}.
  - ARI_I with funct3=001 and instr[31:25]≠0.
  - ARI_I with funct3=101 and instr[31:25] ∉ {0000000,0100000}.
- Illegal bundles still flow; out_reg_we=0 and all is_* flags are 0.
- reg_we is 1 for LUI/AUIPC/JAL/JALR/LOAD/ARI_I/ARI_R/SYSTEM when rd≠0.
- flush=1 at an edge:
  - both entries are invalidated; out_valid=0 next cycle.
  - in_ready=0 during flush, so no accept occurs.
  - flush overrides a simultaneous consume; execute must ignore that bundle.
- Reset mid-stream: all in-flight bundles are lost; no partial bundle is emitted after release.

Test Plan:
- Single R-type: in_instr=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, funct5=01100, funct3=000, bit30=0, rs1=1, rs2=2, rd=3, alu2_imm=0, reg_we=1. Then in_instr=0x402081B3 -> bit30=1.
- Immediates:
  - 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, alu2_imm=1.
  - 0x123452B7 (lui) -> funct5=01101, imm=0x12345000.
  - 0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, is_branch=1, reg_we=0.
- Backpressure: stream 4 instructions with out_ready=0 -> accepts first two, then in_ready=0. Raise out_ready -> all four emerge in order, one per cycle, none lost or duplicated.
- Flush: two bundles buffered, flush=1 for one cycle with in_valid=1 -> out_valid=0 next cycle, in_ready=0 during flush, flushing-cycle instruction not accepted.
- Illegal: 0x00000000 -> out_illegal=1, reg_we=0. 0x202081B3 (bad funct7) -> out_illegal=1. 0x00100013-style addi x0 -> reg_we=0, out_illegal=0.
- Async reset: assert rst_n=0 mid-stream between edges -> out_valid=0 and in_ready=1 immediately. After release, the first output corresponds to the first post-reset accept.
